arm_bus_master: RTL and testbench
=================================

Name: arm_bus_master

Overview:
- Bus initiator that generates ARM-side external-bus cycles (address, as, rs_n, ws_n, be, data) toward FPGA register-file slaves.
- Used to drive and stress those slaves from on-chip logic and benches.
- Accepts one command at a time over a valid/ready handshake, runs a fixed setup/strobe/hold cycle, and returns read data plus a one-cycle completion pulse.
- Always inserts at least one as-low cycle between transactions, so slaves re-arm their one-access-per-select guard.

Parameters:
SETUP_CYCLES, 1, cycles with as=1 and strobes high before the strobe; legal range 1..255
STROBE_CYCLES, 2, cycles with rs_n or ws_n low; legal range 2..255
HOLD_CYCLES, 1, cycles with as=1 and strobes high after the strobe; legal range 1..255

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  high in IDLE; the command is accepted when cmd_valid && cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  24  target address
cmd_wdata  in  32  write data
cmd_be  in  4  byte enables
rsp_valid  out  1  one-cycle pulse at transaction completion (read and write)
rsp_rdata  out  32  captured read data; holds its value until the next read completes
busy  out  1  high in every state except IDLE
bus_address  out  24  registered address to slave
bus_data_out  out  32  registered write data to slave
bus_data_in  in  32  slave read data
bus_as  out  1  chip select, active-high
bus_rs_n  out  1  read strobe, active-low
bus_ws_n  out  1  write strobe, active-low
bus_be  out  4  byte enables to slave

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any state, including mid-transaction):
  - state IDLE, counter 0
  - bus_as=0, bus_rs_n=1, bus_ws_n=1
  - bus_address=0, bus_data_out=0, bus_be=0
  - rsp_valid=0, rsp_rdata=0, busy=0
  - cmd_ready=1 after reset release
  - An interrupted transaction is abandoned; no rsp_valid is issued for it.
- States: IDLE, SETUP, STROBE, HOLD. 8-bit phase counter, loaded on each state entry.
- IDLE:
  - bus_as=0, both strobes high.
  - On accept: latch cmd fields into bus_address/bus_data_out/bus_be and an internal write flag; go to SETUP.
  - Accept in IDLE guarantees at least one clk edge with as=0 between transactions.
- SETUP:
  - bus_as=1, strobes high, for SETUP_CYCLES cycles, then go to STROBE.
- STROBE:
  - bus_as=1; bus_ws_n=0 for a write, bus_rs_n=0 for a read (never both low).
  - Lasts STROBE_CYCLES cycles.
  - For a read, rsp_rdata <= bus_data_in on the clock edge that leaves STROBE. The slave updates its data_out on the first strobe edge, so STROBE_CYCLES >= 2 is mandatory.
  - Then go to HOLD.
- HOLD:
  - bus_as=1, strobes high, address/data/be still driven, for HOLD_CYCLES cycles.
  - Then go to IDLE; rsp_valid=1 for exactly the first IDLE cycle.
- Bus fields are held stable from SETUP through the last HOLD cycle; they retain their values in IDLE (no toggling).
- Latency from accept edge to rsp_valid high = SETUP_CYCLES + STROBE_CYCLES + HOLD_CYCLES + 1 cycles (5 with defaults).
- Back-to-back commands:
  - cmd_ready is high in the rsp_valid cycle, so a new accept may occur there.
  - Issue rate: one transaction per SETUP + STROBE + HOLD + 1 cycles.
- cmd_valid while busy: ignored, no queueing. Command fields are sampled only at accept.
- Writes do not modify rsp_rdata.
- Parameters outside their legal range are a configuration error; an elaboration-time check is required.

Decomposition:
- Shared package arm_bus_pkg:
  - state encoding for IDLE/SETUP/STROBE/HOLD
  - bus idle constants (AS_IDLE=0, STROBE_IDLE=1)
  - bus widths (ADDR_W=24, DATA_W=32, BE_W=4)
- Single module; no sub-module is warranted. The phase counter stays inline.

Test Plan:
- Reset: assert rst_n=0 mid-STROBE of a read -> bus_as=0, bus_rs_n=1, rsp_valid never pulses, rsp_rdata=0, cmd_ready=1 after release.
- Write timing:
  - Stimulus: cmd write addr 0x000000, wdata 0x00000001, be 0xF, accepted at edge T.
  - Required: T+1 bus_as=1 with strobes high; T+2..T+3 bus_ws_n=0 and bus_rs_n=1; T+4 strobes high with as=1; T+5 bus_as=0 and rsp_valid=1 for one cycle.
- Read against the register-file model after the write above: read addr 0 -> rsp_rdata=0x80200003; a second read -> 0xC0300002.
- Back-to-back:
  - Stimulus: cmd_valid held high with two reads.
  - Required: second accept occurs in the first rsp_valid cycle; exactly one bus_as=0 cycle between transactions; slave returns fresh data both times.
- cmd_valid pulsed during STROBE -> ignored; exactly one rsp_valid pulse; bus fields unchanged.
- Parameter sweep (SETUP=3, STROBE=4, HOLD=2): strobe low for exactly 4 cycles; rsp_valid exactly 10 cycles after accept.

Source files
------------

// File: rtl/arm_bus_pkg.sv
// Shared definitions for the ARM-side external-bus initiator.
//   - Bus widths (address, data, byte enables)
//   - Idle levels of the chip select and the active-low strobes
//   - Bus-cycle phase encoding
//   - Helper that turns a phase length into the phase-counter load value
package arm_bus_pkg;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    localparam logic AS_IDLE     = 1'b0;
    localparam logic STROBE_IDLE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    // The counter counts down to zero, so a phase of N cycles loads N-1.
    function automatic logic [7:0] phase_load(input int cycles);
        return 8'(cycles - 1);
    endfunction

endpackage

// File: rtl/arm_bus_master.sv
// arm_bus_master: issues one external-bus cycle per accepted command toward
// an FPGA register-file slave: SETUP (as=1, strobes high), STROBE (rs_n or
// ws_n low), HOLD (as=1, strobes high), then back to IDLE with a one-cycle
// rsp_valid. Every returned-to-IDLE cycle drives as=0, so the slave always
// sees a deselect between two accesses.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   cmd_valid/ready   command handshake (accept = cmd_valid && cmd_ready)
//   cmd_write         1 = write, 0 = read
//   cmd_addr/wdata/be command fields, sampled only at accept
//   rsp_valid         one-cycle completion pulse (reads and writes)
//   rsp_rdata         last read data, held until the next read completes
//   busy              high whenever not IDLE
//   bus_address       address to slave
//   bus_data_out      write data to slave
//   bus_data_in       read data from slave
//   bus_as            chip select, active-high
//   bus_rs_n/bus_ws_n read/write strobes, active-low
//   bus_be            byte enables to slave
// All outputs are registered.
module arm_bus_master
    import arm_bus_pkg::*;
#(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [BE_W-1:0]   cmd_be,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] bus_address,
    output logic [DATA_W-1:0] bus_data_out,
    input  logic [DATA_W-1:0] bus_data_in,
    output logic              bus_as,
    output logic              bus_rs_n,
    output logic              bus_ws_n,
    output logic [BE_W-1:0]   bus_be
);

    // Configuration check at elaboration. The slave only refreshes its
    // read data on the first strobe edge, so a 1-cycle strobe would
    // capture stale data.
    if (SETUP_CYCLES < 1 || SETUP_CYCLES > 255) begin : g_bad_setup
        $error("arm_bus_master: SETUP_CYCLES must be in 1..255");
    end
    if (STROBE_CYCLES < 2 || STROBE_CYCLES > 255) begin : g_bad_strobe
        $error("arm_bus_master: STROBE_CYCLES must be in 2..255");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
        $error("arm_bus_master: HOLD_CYCLES must be in 1..255");
    end

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        wr_q;
    logic        accept;
    logic        capture_rd;

    logic        as_d, rs_n_d, ws_n_d, rsp_valid_d, ready_d, busy_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the counter is reloaded on every state entry.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        capture_rd = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept  = 1'b1;
                    state_d = ST_SETUP;
                    cnt_d   = phase_load(SETUP_CYCLES);
                end
            end
            ST_SETUP: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_STROBE;
                    cnt_d   = phase_load(STROBE_CYCLES);
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_STROBE: begin
                if (cnt_q == 8'd0) begin
                    state_d    = ST_HOLD;
                    cnt_d      = phase_load(HOLD_CYCLES);
                    capture_rd = !wr_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Output logic: decoded from the next state so the registered bus
    // pins line up with the state they belong to.
    always_comb begin
        as_d        = (state_d != ST_IDLE) ? 1'b1 : AS_IDLE;
        rs_n_d      = STROBE_IDLE;
        ws_n_d      = STROBE_IDLE;
        if (state_d == ST_STROBE) begin
            if (wr_q) ws_n_d = 1'b0;
            else      rs_n_d = 1'b0;
        end
        rsp_valid_d = (state_q == ST_HOLD) && (state_d == ST_IDLE);
        ready_d     = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    // Registered outputs and latched command fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_as       <= AS_IDLE;
            bus_rs_n     <= STROBE_IDLE;
            bus_ws_n     <= STROBE_IDLE;
            bus_address  <= '0;
            bus_data_out <= '0;
            bus_be       <= '0;
            wr_q         <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            busy         <= 1'b0;
            cmd_ready    <= 1'b1;
        end else begin
            bus_as    <= as_d;
            bus_rs_n  <= rs_n_d;
            bus_ws_n  <= ws_n_d;
            rsp_valid <= rsp_valid_d;
            busy      <= busy_d;
            cmd_ready <= ready_d;
            // Bus fields only change at accept, so they stay stable
            // through the whole cycle and do not toggle in IDLE.
            if (accept) begin
                bus_address  <= cmd_addr;
                bus_data_out <= cmd_wdata;
                bus_be       <= cmd_be;
                wr_q         <= cmd_write;
            end
            if (capture_rd) begin
                rsp_rdata <= bus_data_in;
            end
        end
    end

endmodule

// File: tb/tb_arm_bus_master.sv
module tb_arm_bus_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_valid2;
    logic        cmd_write;
    logic [23:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_be;

    logic        cmd_ready, rsp_valid, busy, bus_as, bus_rs_n, bus_ws_n;
    logic [31:0] rsp_rdata, bus_data_out;
    logic [23:0] bus_address;
    logic [3:0]  bus_be;
    logic [31:0] bus_data_in = 32'h0;

    logic        cmd_ready2, rsp_valid2, busy2, bus_as2, bus_rs_n2, bus_ws_n2;
    logic [31:0] rsp_rdata2, bus_data_out2;
    logic [23:0] bus_address2;
    logic [3:0]  bus_be2;
    logic [31:0] bus_data_in2;

    int n_cmp = 0;
    int n_err = 0;
    int rsp_cnt = 0;

    always #5 clk = ~clk;

    arm_bus_master dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .bus_address(bus_address), .bus_data_out(bus_data_out),
        .bus_data_in(bus_data_in), .bus_as(bus_as), .bus_rs_n(bus_rs_n),
        .bus_ws_n(bus_ws_n), .bus_be(bus_be)
    );

    arm_bus_master #(.SETUP_CYCLES(3), .STROBE_CYCLES(4), .HOLD_CYCLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .busy(busy2),
        .bus_address(bus_address2), .bus_data_out(bus_data_out2),
        .bus_data_in(bus_data_in2), .bus_as(bus_as2), .bus_rs_n(bus_rs_n2),
        .bus_ws_n(bus_ws_n2), .bus_be(bus_be2)
    );

    assign bus_data_in2 = 32'hDEADBEEF;

    // Register-file slave: a Galois LFSR register (taps 0x80200003).
    // A write loads it; each read select advances it once on the first
    // strobe edge and presents the new value. One access per as assertion.
    logic [31:0] lfsr  = 32'h0;
    logic        armed = 1'b0;

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? 32'h80200003 : 32'h0);
    endfunction

    function automatic logic [31:0] be_merge(input logic [31:0] old,
                                             input logic [31:0] nw,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (!bus_as) begin
            armed <= 1'b1;
        end else if (armed && !bus_ws_n) begin
            lfsr  <= be_merge(lfsr, bus_data_out, bus_be);
            armed <= 1'b0;
        end else if (armed && !bus_rs_n) begin
            lfsr        <= lfsr_next(lfsr);
            bus_data_in <= lfsr_next(lfsr);
            armed       <= 1'b0;
        end
    end

    always @(negedge clk) if (rsp_valid === 1'b1) rsp_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a command to dut; returns #1 after the accept edge.
    task automatic issue(input logic w, input logic [23:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_be = b;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    int base;
    int first_lo, lo_cnt, rsp_k;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_valid2 = 1'b0;
        cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_be = '0;
        repeat (3) step();

        // Reset state
        chk("rst_as", {31'b0, bus_as}, 32'h0);
        chk("rst_rs_n", {31'b0, bus_rs_n}, 32'h1);
        chk("rst_ws_n", {31'b0, bus_ws_n}, 32'h1);
        chk("rst_addr", {8'b0, bus_address}, 32'h0);
        chk("rst_dout", bus_data_out, 32'h0);
        chk("rst_be", {28'b0, bus_be}, 32'h0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        rst_n = 1'b1;
        step();
        chk("rst_ready", {31'b0, cmd_ready}, 32'h1);

        // Reset asserted mid-STROBE of a read
        base = rsp_cnt;
        issue(1'b0, 24'h123456, 32'h0, 4'hF);
        chk("mid_setup_as", {31'b0, bus_as}, 32'h1);
        step();
        chk("mid_strobe_rs_n", {31'b0, bus_rs_n}, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_as", {31'b0, bus_as}, 32'h0);
        chk("mid_rst_rs_n", {31'b0, bus_rs_n}, 32'h1);
        chk("mid_rst_busy", {31'b0, busy}, 32'h0);
        chk("mid_rst_addr", {8'b0, bus_address}, 32'h0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (8) step();
        chk("mid_rst_no_rsp", rsp_cnt - base, 32'h0);
        chk("mid_rst_rdata", rsp_rdata, 32'h0);
        chk("mid_rst_ready", {31'b0, cmd_ready}, 32'h1);

        // Write timing: k = cycle number after the accept edge
        issue(1'b1, 24'h000000, 32'h00000001, 4'hF);
        chk("wr_k1_as", {31'b0, bus_as}, 32'h1);
        chk("wr_k1_strobes", {30'b0, bus_rs_n, bus_ws_n}, 32'h3);
        chk("wr_k1_dout", bus_data_out, 32'h00000001);
        chk("wr_k1_be", {28'b0, bus_be}, 32'hF);
        step();
        chk("wr_k2_strobes", {30'b0, bus_rs_n, bus_ws_n}, 32'h2);
        step();
        chk("wr_k3_strobes", {30'b0, bus_rs_n, bus_ws_n}, 32'h2);
        step();
        chk("wr_k4_as_strobes", {29'b0, bus_as, bus_rs_n, bus_ws_n}, 32'h7);
        step();
        chk("wr_k5_as", {31'b0, bus_as}, 32'h0);
        chk("wr_k5_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        step();
        chk("wr_k6_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("wr_rdata_untouched", rsp_rdata, 32'h0);

        // Two reads against the LFSR register
        issue(1'b0, 24'h000000, 32'h0, 4'hF);
        step();
        chk("rd1_strobes", {30'b0, bus_rs_n, bus_ws_n}, 32'h1);
        repeat (3) step();
        chk("rd1_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        chk("rd1_rdata", rsp_rdata, 32'h80200003);
        step();
        issue(1'b0, 24'h000000, 32'h0, 4'hF);
        repeat (4) step();
        chk("rd2_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        chk("rd2_rdata", rsp_rdata, 32'hC0300002);
        step();

        // Back-to-back reads with cmd_valid held high
        cmd_write = 1'b0; cmd_addr = 24'h000000; cmd_be = 4'hF;
        cmd_valid = 1'b1;
        step();
        repeat (4) step();
        chk("b2b_k5_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        chk("b2b_k5_as", {31'b0, bus_as}, 32'h0);
        chk("b2b_k5_ready", {31'b0, cmd_ready}, 32'h1);
        chk("b2b_rd3_rdata", rsp_rdata, 32'h60180001);
        step();
        cmd_valid = 1'b0;
        chk("b2b_k6_as", {31'b0, bus_as}, 32'h1);
        chk("b2b_k6_busy", {31'b0, busy}, 32'h1);
        repeat (4) step();
        chk("b2b_k10_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        chk("b2b_rd4_rdata", rsp_rdata, 32'hB02C0003);
        step();
        chk("b2b_k11_busy", {31'b0, busy}, 32'h0);

        // cmd_valid pulsed during STROBE is ignored
        base = rsp_cnt;
        issue(1'b1, 24'hABCDEF, 32'h5A5A5A5A, 4'h3);
        step();
        cmd_write = 1'b0; cmd_addr = 24'h111111; cmd_wdata = 32'h0; cmd_be = 4'hC;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("ign_addr", {8'b0, bus_address}, 32'h00ABCDEF);
        chk("ign_dout", bus_data_out, 32'h5A5A5A5A);
        chk("ign_be", {28'b0, bus_be}, 32'h3);
        chk("ign_ws_n", {31'b0, bus_ws_n}, 32'h0);
        repeat (10) step();
        chk("ign_one_rsp", rsp_cnt - base, 32'h1);
        chk("ign_idle_busy", {31'b0, busy}, 32'h0);
        chk("ign_idle_addr_kept", {8'b0, bus_address}, 32'h00ABCDEF);
        chk("ign_rdata_untouched", rsp_rdata, 32'hB02C0003);

        // Parameter sweep instance: SETUP=3, STROBE=4, HOLD=2
        cmd_write = 1'b0; cmd_addr = 24'h000042; cmd_wdata = 32'h0; cmd_be = 4'hF;
        cmd_valid2 = 1'b1;
        step();
        cmd_valid2 = 1'b0;
        first_lo = 0; lo_cnt = 0; rsp_k = 0;
        for (int k = 1; k <= 14; k++) begin
            if (bus_rs_n2 === 1'b0) begin
                lo_cnt++;
                if (first_lo == 0) first_lo = k;
            end
            if (rsp_valid2 === 1'b1 && rsp_k == 0) rsp_k = k;
            step();
        end
        chk("sweep_first_strobe", first_lo, 32'd4);
        chk("sweep_strobe_len", lo_cnt, 32'd4);
        chk("sweep_rsp_latency", rsp_k, 32'd10);
        chk("sweep_rdata", rsp_rdata2, 32'hDEADBEEF);
        chk("sweep_idle_as", {31'b0, bus_as2}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
